// File: rtl/reg_file.sv
// Register file: two combinational read ports, one write-back port, r0 hard-wired to zero,
// plus ALU overflow flag capture. Define REG_FILE_BYPASS_EN for same-cycle write-to-read forwarding.
module reg_file #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] rd_addr_a,
  input  logic [ADDR_WIDTH-1:0] rd_addr_b,
  output logic [DATA_WIDTH-1:0] rd_data_a,
  output logic [DATA_WIDTH-1:0] rd_data_b,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  flag_we,
  input  logic                  shift_ovf_in,
  input  logic                  arith_ovf_in,
  input  logic                  flag_clr,
  output logic [3:0]            flags,
  output logic                  zero_flag
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic                  last_shift_q, last_shift_d;
  logic                  last_arith_q, last_arith_d;
  logic                  sticky_shift_q, sticky_shift_d;
  logic                  sticky_arith_q, sticky_arith_d;
  logic                  zero_q, zero_d;
  logic                  wr_commit;

  // Writes to r0 are dropped entirely: neither the array nor zero_flag sees them.
  assign wr_commit = wr_en && (wr_addr != '0);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    regs_d = regs_q;
    if (wr_commit) begin
      regs_d[wr_addr] = wr_data;
    end
  end

  always_comb begin
    last_shift_d = last_shift_q;
    last_arith_d = last_arith_q;
    if (flag_we) begin
      last_shift_d = shift_ovf_in;
      last_arith_d = arith_ovf_in;
    end
    // Clear acts on the old sticky value; a same-cycle set still lands.
    sticky_shift_d = (sticky_shift_q && !flag_clr) || (flag_we && shift_ovf_in);
    sticky_arith_d = (sticky_arith_q && !flag_clr) || (flag_we && arith_ovf_in);
    zero_d = wr_commit ? (wr_data == '0) : zero_q;
  end

  // NOTE: the storage array is reset too, because every register must read 0 after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      last_shift_q   <= 1'b0;
      last_arith_q   <= 1'b0;
      sticky_shift_q <= 1'b0;
      sticky_arith_q <= 1'b0;
      zero_q         <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here keep every register updating from pre-edge values.
      regs_q         <= regs_d;
      last_shift_q   <= last_shift_d;
      last_arith_q   <= last_arith_d;
      sticky_shift_q <= sticky_shift_d;
      sticky_arith_q <= sticky_arith_d;
      zero_q         <= zero_d;
    end
  end

  always_comb begin
    rd_data_a = regs_q[rd_addr_a];
    rd_data_b = regs_q[rd_addr_b];
`ifdef REG_FILE_BYPASS_EN
    if (wr_commit && !reset && (rd_addr_a == wr_addr)) begin
      rd_data_a = wr_data;
    end
    if (wr_commit && !reset && (rd_addr_b == wr_addr)) begin
      rd_data_b = wr_data;
    end
`endif
    if (rd_addr_a == '0) begin
      rd_data_a = '0;
    end
    if (rd_addr_b == '0) begin
      rd_data_b = '0;
    end
  end

  assign flags     = {sticky_arith_q, sticky_shift_q, last_arith_q, last_shift_q};
  assign zero_flag = zero_q;

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: table-driven vectors plus hand sequences for
// reset sweeps and same-cycle read-during-write.
module tb_reg_file;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] rd_addr_a, rd_addr_b;
  logic [7:0] rd_data_a, rd_data_b;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       flag_we, shift_ovf_in, arith_ovf_in, flag_clr;
  logic [3:0] flags;
  logic       zero_flag;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reg_file #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .rd_addr_a    (rd_addr_a),
    .rd_addr_b    (rd_addr_b),
    .rd_data_a    (rd_data_a),
    .rd_data_b    (rd_data_b),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .flag_we      (flag_we),
    .shift_ovf_in (shift_ovf_in),
    .arith_ovf_in (arith_ovf_in),
    .flag_clr     (flag_clr),
    .flags        (flags),
    .zero_flag    (zero_flag)
  );

  typedef struct {
    logic       rst;
    logic       we;
    logic [3:0] wa;
    logic [7:0] wd;
    logic       fwe;
    logic       sh;
    logic       ar;
    logic       clr;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [7:0] ea;
    logic [7:0] eb;
    logic [3:0] ef;
    logic       ez;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    flag_we = 1'b0; shift_ovf_in = 1'b0; arith_ovf_in = 1'b0; flag_clr = 1'b0;
  endtask

  task automatic sweep_zero(input string tag);
    for (int i = 0; i < 16; i++) begin
      rd_addr_a = 4'(i);
      rd_addr_b = 4'(15 - i);
      #1;
      check($sformatf("%s rd_a[%0d]", tag, i), 32'(rd_data_a), 32'h00);
      check($sformatf("%s rd_b[%0d]", tag, 15 - i), 32'(rd_data_b), 32'h00);
    end
  endtask

  initial begin
    //            rst we  wa     wd     fwe sh  ar  clr ra     rb     ea     eb     ef       ez
    vecs[0]  = '{1'b1, 1'b1, 4'd7,  8'h55, 1'b1, 1'b0, 1'b1, 1'b0, 4'd7,  4'd0,  8'h00, 8'h00, 4'b0000, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 4'd5,  8'hA3, 1'b0, 1'b0, 1'b0, 1'b0, 4'd5,  4'd0,  8'hA3, 8'h00, 4'b0000, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 4'd0,  8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  4'd5,  8'h00, 8'hA3, 4'b0000, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 4'd7,  8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd7,  4'd5,  8'h00, 8'hA3, 4'b0000, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 4'd0,  8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  4'd7,  8'h00, 8'h00, 4'b0000, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 4'd7,  8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 4'd7,  4'd7,  8'h01, 8'h01, 4'b0000, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 4'd15, 8'hC4, 1'b0, 1'b0, 1'b0, 1'b0, 4'd15, 4'd7,  8'hC4, 8'h01, 4'b0000, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 4'd0,  8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 4'd15, 4'd5,  8'hC4, 8'hA3, 4'b1010, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 4'd0,  8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1,  4'd7,  8'h00, 8'h01, 4'b1000, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 4'd0,  8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 4'd5,  4'd5,  8'hA3, 8'hA3, 4'b0101, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 4'd0,  8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 4'd5,  4'd15, 8'hA3, 8'hC4, 4'b0101, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 4'd0,  8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 4'd7,  4'd0,  8'h01, 8'h00, 4'b0001, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 4'd3,  8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3,  4'd15, 8'h11, 8'hC4, 4'b0001, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 4'd7,  8'h55, 1'b1, 1'b1, 1'b1, 1'b0, 4'd7,  4'd15, 8'h00, 8'h00, 4'b0000, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 4'd2,  8'h9A, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2,  4'd7,  8'h9A, 8'h00, 4'b0000, 1'b0};

    idle();
    rd_addr_a = '0;
    rd_addr_b = '0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    sweep_zero("post-reset");
    check("post-reset flags", 32'(flags), 32'h0);
    check("post-reset zero_flag", 32'(zero_flag), 32'h0);

    for (int v = 0; v < NV; v++) begin
      reset        = vecs[v].rst;
      wr_en        = vecs[v].we;
      wr_addr      = vecs[v].wa;
      wr_data      = vecs[v].wd;
      flag_we      = vecs[v].fwe;
      shift_ovf_in = vecs[v].sh;
      arith_ovf_in = vecs[v].ar;
      flag_clr     = vecs[v].clr;
      rd_addr_a    = vecs[v].ra;
      rd_addr_b    = vecs[v].rb;
      tick();
      check($sformatf("vec%0d rd_a", v), 32'(rd_data_a), 32'(vecs[v].ea));
      check($sformatf("vec%0d rd_b", v), 32'(rd_data_b), 32'(vecs[v].eb));
      check($sformatf("vec%0d flags", v), 32'(flags), 32'(vecs[v].ef));
      check($sformatf("vec%0d zero_flag", v), 32'(zero_flag), 32'(vecs[v].ez));
    end

    // Read-during-write on r3 (holds 0x11): forwarded only in the bypass build.
    idle();
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 8'h11;
    tick();
    wr_data = 8'h7E;
    rd_addr_a = 4'd3;
    rd_addr_b = 4'd3;
    #1;
`ifdef REG_FILE_BYPASS_EN
    check("rdw same-cycle rd_a", 32'(rd_data_a), 32'h7E);
    check("rdw same-cycle rd_b", 32'(rd_data_b), 32'h7E);
`else
    check("rdw same-cycle rd_a", 32'(rd_data_a), 32'h11);
    check("rdw same-cycle rd_b", 32'(rd_data_b), 32'h11);
`endif
    tick();
    wr_en = 1'b0;
    #1;
    check("rdw next-cycle rd_a", 32'(rd_data_a), 32'h7E);
    check("rdw next-cycle rd_b", 32'(rd_data_b), 32'h7E);

    // r0 must stay zero even while a write to r0 is in flight.
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'hFF;
    rd_addr_a = 4'd0;
    #1;
    check("r0 during write", 32'(rd_data_a), 32'h00);
    tick();
    check("r0 after write", 32'(rd_data_a), 32'h00);

    // Reset with a write pending, then the first write after reset lands.
    idle();
    reset = 1'b1; wr_en = 1'b1; wr_addr = 4'd3; wr_data = 8'h66;
    tick();
    idle();
    sweep_zero("late-reset");
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 8'h00;
    tick();
    wr_en = 1'b0;
    rd_addr_a = 4'd3;
    #1;
    check("first write after reset", 32'(rd_data_a), 32'h00);
    check("zero_flag after reset write", 32'(zero_flag), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
